// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder.
// Contents: bus/DDRAM widths, command opcode prefixes, AC boundaries, the
// fill character, FSM/command enums, the latched bus transaction payload,
// and helpers for command decode and address-counter stepping.
package lcd_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned AC_W        = 7;
  localparam int unsigned DDRAM_AW    = 5;
  localparam int unsigned DDRAM_DEPTH = 32;

  // Command opcode prefixes: the highest set bit selects the command
  localparam logic [DATA_W-1:0] OP_SET_DDRAM = 8'h80;
  localparam logic [DATA_W-1:0] OP_SET_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] OP_FUNC_SET  = 8'h20;
  localparam logic [DATA_W-1:0] OP_SHIFT     = 8'h10;
  localparam logic [DATA_W-1:0] OP_DISP_CTRL = 8'h08;
  localparam logic [DATA_W-1:0] OP_ENTRY     = 8'h04;
  localparam logic [DATA_W-1:0] OP_HOME      = 8'h02;
  localparam logic [DATA_W-1:0] OP_CLEAR     = 8'h01;

  // Address counter boundaries for a two-line display
  localparam logic [AC_W-1:0] LINE2_BASE = 7'h40;
  localparam logic [AC_W-1:0] LINE1_END  = 7'h27;
  localparam logic [AC_W-1:0] LINE2_END  = 7'h67;

  // Character written into every cell by the clear sweep
  localparam logic [DATA_W-1:0] FILL_CHAR = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    CMD_NONE,
    CMD_SET_DDRAM,
    CMD_SET_CGRAM,
    CMD_FUNC_SET,
    CMD_SHIFT,
    CMD_DISP_CTRL,
    CMD_ENTRY,
    CMD_HOME,
    CMD_CLEAR
  } cmd_t;

  // One bus transaction as latched while EN is high
  typedef struct packed {
    logic              rs;
    logic              rw;
    logic [DATA_W-1:0] data;
  } bus_xact_t;

  // Decode an rs=0 write byte by its highest set bit
  function automatic cmd_t decode_cmd(input logic [DATA_W-1:0] d);
    cmd_t c;
    if ((d & OP_SET_DDRAM) != '0)      c = CMD_SET_DDRAM;
    else if ((d & OP_SET_CGRAM) != '0) c = CMD_SET_CGRAM;
    else if ((d & OP_FUNC_SET) != '0)  c = CMD_FUNC_SET;
    else if ((d & OP_SHIFT) != '0)     c = CMD_SHIFT;
    else if ((d & OP_DISP_CTRL) != '0) c = CMD_DISP_CTRL;
    else if ((d & OP_ENTRY) != '0)     c = CMD_ENTRY;
    else if ((d & OP_HOME) != '0)      c = CMD_HOME;
    else if ((d & OP_CLEAR) != '0)     c = CMD_CLEAR;
    else                               c = CMD_NONE;
    return c;
  endfunction

  // Step the address counter, skipping the unused gap between the lines
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac,
                                              input logic            inc);
    logic [AC_W-1:0] nxt;
    if (inc) begin
      if (ac == LINE1_END)      nxt = LINE2_BASE;
      else if (ac == LINE2_END) nxt = '0;
      else                      nxt = ac + AC_W'(1);
    end else begin
      if (ac == LINE2_BASE)     nxt = LINE1_END;
      else if (ac == '0)        nxt = LINE2_END;
      else                      nxt = ac - AC_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 character RAM holding the visible 2x16 screen image.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (read register only)
//   i_we/i_waddr/i_wdata  single write port
//   i_raddr/o_rdata   synchronous read port, one-cycle latency, resets to 0
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [DDRAM_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DDRAM_AW-1:0] i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [DDRAM_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array; contents are initialised by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; returns the pre-write value on a same-address collision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_bus_responder.sv
// Device end of an HD44780-style 8-bit LCD bus: decodes command/data
// writes, keeps a 2x16 DDRAM image, and answers busy-flag/address reads.
// Optional feature macro: LCD_RESP_BUSY_EN adds the post-write busy counter;
// without it busy is asserted only during the clear sweep.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   lcd_en/rs/rw        bus strobes from the controller
//   lcd_data_in         controller-driven bus value
//   lcd_data_out        registered read return ({busy, AC} or 0x00)
//   lcd_data_oe         drive enable for the inout tie-off (follows lcd_rw)
//   rd_addr/rd_data     debug screen read, one-cycle latency
//   display_on          D bit of the last display-control command
//   init_seen           sticky flag set by the first function set
//   protocol_err        one-cycle pulse when a write is dropped
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES       = 4,
  parameter int unsigned CLEAR_BUSY_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lcd_en,
  input  logic                lcd_rs,
  input  logic                lcd_rw,
  input  logic [DATA_W-1:0]   lcd_data_in,
  output logic [DATA_W-1:0]   lcd_data_out,
  output logic                lcd_data_oe,
  input  logic [DDRAM_AW-1:0] rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                display_on,
  output logic                init_seen,
  output logic                protocol_err
);

  bus_xact_t           r_xact;
  logic                r_en_q;
  logic                r_exec;
  state_t              r_state;
  logic [DDRAM_AW-1:0] r_sweep_idx;
  logic [AC_W-1:0]     r_ac;
  logic                r_id;
  logic                r_display_on;
  logic                r_init_seen;
  logic                r_protocol_err;
  logic [DATA_W-1:0]   r_data_out;

  logic                w_fall;
  logic                w_sweep;
  logic                w_busy;
  cmd_t                w_cmd;
  logic                w_is_write;
  logic                w_is_func_set;
  logic                w_drop;
  logic                w_accept_wr;
  logic                w_ac_visible;
  logic                w_host_we;
  logic [DDRAM_AW-1:0] w_host_addr;
  logic                w_mem_we;
  logic [DDRAM_AW-1:0] w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Transaction decode: the execute cycle follows the EN falling-edge cycle
  assign w_fall        = r_en_q & ~lcd_en;
  assign w_sweep       = (r_state == ST_SWEEP);
  assign w_cmd         = decode_cmd(r_xact.data);
  assign w_is_write    = r_exec & ~r_xact.rw;
  assign w_is_func_set = ~r_xact.rs & (w_cmd == CMD_FUNC_SET);
  // Function set bypasses the busy check: the init sequence never polls busy
  assign w_drop        = w_is_write & w_busy & ~w_is_func_set;
  assign w_accept_wr   = w_is_write & ~w_drop;

  // Only AC 0x00-0x0F and 0x40-0x4F map onto visible cells
  assign w_ac_visible  = ((r_ac & 7'h30) == '0);
  assign w_host_addr   = {r_ac[6], r_ac[3:0]};
  // rst_n gate discards a transaction that was mid-execute when reset hit
  assign w_host_we     = rst_n & w_accept_wr & r_xact.rs & w_ac_visible;

  // Sweep owns the write port; host writes are blocked while it runs
  assign w_mem_we    = w_sweep | w_host_we;
  assign w_mem_addr  = w_sweep ? r_sweep_idx : w_host_addr;
  assign w_mem_wdata = w_sweep ? FILL_CHAR : r_xact.data;

`ifdef LCD_RESP_BUSY_EN
  localparam int unsigned BUSY_MAX = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ?
                                     CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int unsigned CNT_W    = $clog2(BUSY_MAX + 1);

  logic [CNT_W-1:0] r_busy_cnt;
  logic             w_loads_busy;
  logic             w_long_busy;

  // Every decoded command and every data write occupies the device
  assign w_loads_busy = r_xact.rs | (w_cmd != CMD_NONE);
  assign w_long_busy  = ~r_xact.rs & ((w_cmd == CMD_HOME) | (w_cmd == CMD_CLEAR));
  assign w_busy       = (r_busy_cnt != '0) | w_sweep;

  // Busy counter: loads in the execute cycle, then counts down to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy_cnt <= '0;
    end else if (w_accept_wr && w_loads_busy) begin
      r_busy_cnt <= w_long_busy ? CNT_W'(CLEAR_BUSY_CYCLES) : CNT_W'(BUSY_CYCLES);
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - CNT_W'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_busy       = w_sweep;
  assign w_unused_cfg = ^{BUSY_CYCLES, CLEAR_BUSY_CYCLES};
`endif

  // Bus capture, command execution and clear-sweep FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_q         <= 1'b0;
      r_exec         <= 1'b0;
      r_xact         <= '0;
      r_state        <= ST_SWEEP;
      r_sweep_idx    <= '0;
      r_ac           <= '0;
      r_id           <= 1'b1;
      r_display_on   <= 1'b0;
      r_init_seen    <= 1'b0;
      r_protocol_err <= 1'b0;
      r_data_out     <= 8'h80;
    end else begin
      r_en_q         <= lcd_en;
      r_exec         <= w_fall;
      r_protocol_err <= w_drop;
      r_data_out     <= lcd_rs ? 8'h00 : {w_busy, r_ac};

      if (lcd_en) begin
        r_xact <= '{rs: lcd_rs, rw: lcd_rw, data: lcd_data_in};
      end

      if (r_state == ST_SWEEP) begin
        r_sweep_idx <= r_sweep_idx + DDRAM_AW'(1);
        if (r_sweep_idx == DDRAM_AW'(DDRAM_DEPTH - 1)) begin
          r_state <= ST_IDLE;
        end
      end

      if (w_accept_wr) begin
        if (r_xact.rs) begin
          r_ac <= ac_step(r_ac, r_id);
        end else begin
          case (w_cmd)
            CMD_SET_DDRAM: r_ac         <= r_xact.data[AC_W-1:0];
            CMD_FUNC_SET:  r_init_seen  <= 1'b1;
            CMD_DISP_CTRL: r_display_on <= r_xact.data[2];
            CMD_ENTRY:     r_id         <= r_xact.data[1];
            CMD_HOME:      r_ac         <= '0;
            CMD_CLEAR: begin
              r_ac        <= '0;
              r_id        <= 1'b1;
              r_state     <= ST_SWEEP;
              r_sweep_idx <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign lcd_data_out = r_data_out;
  assign lcd_data_oe  = lcd_rw;
  assign display_on   = r_display_on;
  assign init_seen    = r_init_seen;
  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed testbench for lcd_bus_responder. Expected values are hand-derived;
// busy-dependent expectations follow LCD_RESP_BUSY_EN.
module tb_lcd_bus_responder;

`ifdef LCD_RESP_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       display_on;
  logic       init_seen;
  logic       protocol_err;

  int n_tests    = 0;
  int n_fail     = 0;
  int err_pulses = 0;

  lcd_bus_responder #(.BUSY_CYCLES(4), .CLEAR_BUSY_CYCLES(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lcd_en       (lcd_en),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .display_on   (display_on),
    .init_seen    (init_seen),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count protocol_err high cycles
  always @(negedge clk) if (protocol_err === 1'b1) err_pulses++;

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_en = 1'b1;
    @(negedge clk);
    lcd_en = 1'b0;
  endtask

  task automatic wr_wait(input logic rs, input logic [7:0] d);
    wr(rs, d);
    idle(12);
  endtask

  task automatic rd_status(output logic [7:0] v, output logic oe);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
    @(negedge clk);
    v = lcd_data_out; oe = lcd_data_oe;
    lcd_en = 1'b0; lcd_rw = 1'b0;
  endtask

  task automatic rd_bus_data(output logic [7:0] v);
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
    @(negedge clk);
    v = lcd_data_out;
    lcd_en = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0;
  endtask

  task automatic rd_cell(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_data_out[7] === 1'b1) cnt++;
      else break;
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    int cnt;
    rst_n = 1'b0;
    idle(3);
    n_tests++; if (lcd_data_out !== 8'h80) begin n_fail++; $display("FAIL reset_data_out: got %h expected 80", lcd_data_out); end
    n_tests++; if (display_on !== 1'b0) begin n_fail++; $display("FAIL reset_display_on: got %b expected 0", display_on); end
    n_tests++; if (init_seen !== 1'b0) begin n_fail++; $display("FAIL reset_init_seen: got %b expected 0", init_seen); end
    n_tests++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_protocol_err: got %b expected 0", protocol_err); end
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    rst_n = 1'b1;
    count_busy(cnt);
    n_tests++; if (cnt != 32) begin n_fail++; $display("FAIL reset_busy_cycles: got %0d expected 32", cnt); end
    rd_cell(5'd0, v);
    n_tests++; if (v !== 8'h20) begin n_fail++; $display("FAIL reset_fill_0: got %h expected 20", v); end
    rd_cell(5'd15, v);
    n_tests++; if (v !== 8'h20) begin n_fail++; $display("FAIL reset_fill_15: got %h expected 20", v); end
    rd_cell(5'd16, v);
    n_tests++; if (v !== 8'h20) begin n_fail++; $display("FAIL reset_fill_16: got %h expected 20", v); end
    rd_cell(5'd31, v);
    n_tests++; if (v !== 8'h20) begin n_fail++; $display("FAIL reset_fill_31: got %h expected 20", v); end
  endtask

  task automatic test_init;
    int e0;
    @(negedge clk) rst_n = 1'b0;
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    idle(23);
    n_tests++; if (init_seen !== 1'b0) begin n_fail++; $display("FAIL init_before: got %b expected 0", init_seen); end
    e0 = err_pulses;
    repeat (5) wr(1'b0, 8'h38);
    idle(60);
    n_tests++; if (err_pulses - e0 != 0) begin n_fail++; $display("FAIL init_no_err: got %0d pulses expected 0", err_pulses - e0); end
    n_tests++; if (init_seen !== 1'b1) begin n_fail++; $display("FAIL init_seen: got %b expected 1", init_seen); end
  endtask

  task automatic test_display;
    wr_wait(1'b0, 8'h0C);
    n_tests++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL disp_on: got %b expected 1", display_on); end
    wr_wait(1'b0, 8'h08);
    n_tests++; if (display_on !== 1'b0) begin n_fail++; $display("FAIL disp_off: got %b expected 0", display_on); end
    wr_wait(1'b0, 8'h0F);
    n_tests++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL disp_on2: got %b expected 1", display_on); end
  endtask

  task automatic test_data;
    logic [7:0] v, exp;
    logic oe;
    wr_wait(1'b0, 8'h80);
    wr_wait(1'b1, 8'h41);
    wr(1'b1, 8'h42);
    idle(2);
    rd_status(v, oe);
    exp = BUSY_EN ? 8'h82 : 8'h02;
    n_tests++; if (v !== exp) begin n_fail++; $display("FAIL data_status_busy: got %h expected %h", v, exp); end
    n_tests++; if (oe !== 1'b1) begin n_fail++; $display("FAIL data_oe_read: got %b expected 1", oe); end
    n_tests++; if (lcd_data_oe !== 1'b0) begin n_fail++; $display("FAIL data_oe_idle: got %b expected 0", lcd_data_oe); end
    idle(10);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h02) begin n_fail++; $display("FAIL data_status_idle: got %h expected 02", v); end
    rd_cell(5'd0, v);
    n_tests++; if (v !== 8'h41) begin n_fail++; $display("FAIL data_cell0: got %h expected 41", v); end
    rd_cell(5'd1, v);
    n_tests++; if (v !== 8'h42) begin n_fail++; $display("FAIL data_cell1: got %h expected 42", v); end
  endtask

  task automatic test_line2;
    logic [7:0] v;
    logic oe;
    wr_wait(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) wr_wait(1'b1, 8'h60 + 8'(i));
    for (int i = 0; i < 16; i++) begin
      rd_cell(5'(16 + i), v);
      n_tests++; if (v !== 8'h60 + 8'(i)) begin n_fail++; $display("FAIL line2_cell%0d: got %h expected %h", 16 + i, v, 8'h60 + 8'(i)); end
    end
    rd_status(v, oe);
    n_tests++; if (v !== 8'h50) begin n_fail++; $display("FAIL line2_ac: got %h expected 50", v); end
    wr_wait(1'b1, 8'hEE);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h51) begin n_fail++; $display("FAIL line2_ac_past: got %h expected 51", v); end
    rd_cell(5'd16, v);
    n_tests++; if (v !== 8'h60) begin n_fail++; $display("FAIL line2_no_store16: got %h expected 60", v); end
    rd_cell(5'd0, v);
    n_tests++; if (v !== 8'h41) begin n_fail++; $display("FAIL line2_no_store0: got %h expected 41", v); end
    rd_bus_data(v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL data_read_zero: got %h expected 00", v); end
    idle(4);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h51) begin n_fail++; $display("FAIL data_read_ac_kept: got %h expected 51", v); end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    logic oe;
    wr_wait(1'b0, 8'hA7);
    wr_wait(1'b1, 8'h55);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h40) begin n_fail++; $display("FAIL wrap_inc_27: got %h expected 40", v); end
    wr_wait(1'b0, 8'h04);
    wr_wait(1'b0, 8'h80);
    wr_wait(1'b1, 8'h33);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h67) begin n_fail++; $display("FAIL wrap_dec_00: got %h expected 67", v); end
    rd_cell(5'd0, v);
    n_tests++; if (v !== 8'h33) begin n_fail++; $display("FAIL wrap_cell0: got %h expected 33", v); end
    wr_wait(1'b0, 8'hC0);
    wr_wait(1'b1, 8'h34);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h27) begin n_fail++; $display("FAIL wrap_dec_40: got %h expected 27", v); end
    rd_cell(5'd16, v);
    n_tests++; if (v !== 8'h34) begin n_fail++; $display("FAIL wrap_cell16: got %h expected 34", v); end
    wr_wait(1'b0, 8'h06);
    wr_wait(1'b0, 8'hE7);
    wr_wait(1'b1, 8'h35);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL wrap_inc_67: got %h expected 00", v); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v, exp;
    logic oe;
    int e0;
    wr_wait(1'b0, 8'h80);
    e0 = err_pulses;
    wr(1'b1, 8'h61);
    wr(1'b1, 8'h62);
    idle(12);
    n_tests++; if (err_pulses - e0 != (BUSY_EN ? 1 : 0)) begin n_fail++; $display("FAIL b2b_err: got %0d pulses expected %0d", err_pulses - e0, BUSY_EN ? 1 : 0); end
    rd_cell(5'd0, v);
    n_tests++; if (v !== 8'h61) begin n_fail++; $display("FAIL b2b_cell0: got %h expected 61", v); end
    rd_cell(5'd1, v);
    exp = BUSY_EN ? 8'h42 : 8'h62;
    n_tests++; if (v !== exp) begin n_fail++; $display("FAIL b2b_cell1: got %h expected %h", v, exp); end
    rd_status(v, oe);
    exp = BUSY_EN ? 8'h01 : 8'h02;
    n_tests++; if (v !== exp) begin n_fail++; $display("FAIL b2b_ac: got %h expected %h", v, exp); end
  endtask

  task automatic test_home;
    logic [7:0] v, exp;
    logic oe;
    wr_wait(1'b0, 8'h85);
    wr(1'b0, 8'h02);
    idle(20);
    rd_status(v, oe);
    exp = BUSY_EN ? 8'h80 : 8'h00;
    n_tests++; if (v !== exp) begin n_fail++; $display("FAIL home_busy: got %h expected %h", v, exp); end
    idle(60);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL home_done: got %h expected 00", v); end
  endtask

  task automatic test_clear;
    logic [7:0] v;
    logic oe;
    int e0;
    wr_wait(1'b0, 8'h04);
    e0 = err_pulses;
    wr(1'b0, 8'h01);
    wr(1'b1, 8'h77);
    idle(80);
    n_tests++; if (err_pulses - e0 != 1) begin n_fail++; $display("FAIL clear_drop_err: got %0d pulses expected 1", err_pulses - e0); end
    for (int i = 0; i < 32; i++) begin
      rd_cell(5'(i), v);
      n_tests++; if (v !== 8'h20) begin n_fail++; $display("FAIL clear_cell%0d: got %h expected 20", i, v); end
    end
    rd_status(v, oe);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL clear_ac: got %h expected 00", v); end
    wr_wait(1'b1, 8'h41);
    rd_status(v, oe);
    n_tests++; if (v !== 8'h01) begin n_fail++; $display("FAIL clear_id_inc: got %h expected 01", v); end
    rd_cell(5'd0, v);
    n_tests++; if (v !== 8'h41) begin n_fail++; $display("FAIL clear_post_write: got %h expected 41", v); end
  endtask

  task automatic test_reset_mid;
    int cnt;
    wr(1'b0, 8'h01);
    idle(6);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (lcd_data_out !== 8'h80) begin n_fail++; $display("FAIL rmid_data_out: got %h expected 80", lcd_data_out); end
    n_tests++; if (display_on !== 1'b0) begin n_fail++; $display("FAIL rmid_display_on: got %b expected 0", display_on); end
    n_tests++; if (init_seen !== 1'b0) begin n_fail++; $display("FAIL rmid_init_seen: got %b expected 0", init_seen); end
    rst_n = 1'b1;
    count_busy(cnt);
    n_tests++; if (cnt != 32) begin n_fail++; $display("FAIL rmid_busy_cycles: got %0d expected 32", cnt); end
  endtask

  initial begin
    rst_n = 1'b0; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data_in = 8'h00; rd_addr = 5'd0;
    test_reset;
    test_init;
    test_display;
    test_data;
    test_line2;
    test_wrap;
    test_back_to_back;
    test_home;
    test_clear;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
